// File: rtl/rom_loader.sv
// Boot-time loader for the Hack instruction ROM. It parses a framed byte stream into 16-bit words
// and holds the CPU in reset until the image is stored. Define ROM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module rom_loader (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [14:0] rom_addr,
    output logic [15:0] rom_data,
    output logic        rom_we,
    output logic        cpu_reset,
    output logic        done,
    output logic        error
);

    localparam int unsigned AW = 15;
    localparam int unsigned DW = 16;
    localparam int unsigned BW = 8;
    localparam logic [BW-1:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LEN_HI  = 3'd1,
        S_LEN_LO  = 3'd2,
        S_DATA_HI = 3'd3,
        S_DATA_LO = 3'd4,
`ifdef ROM_LOADER_CHECKSUM_EN
        S_CSUM    = 3'd5,
`endif
        S_DONE    = 3'd6,
        S_ERR     = 3'd7
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic          we_q, we_d;
    logic          cpu_reset_q, cpu_reset_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic [AW-1:0] len_q, len_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] hi_q, hi_d;
    logic          body_end;
    logic          finish;

`ifdef ROM_LOADER_CHECKSUM_EN
    logic [BW-1:0] csum_q, csum_d;

    // Running XOR over length and data bytes; cleared by each sync byte that opens a frame.
    always_comb begin
        csum_d = csum_q;
        if (rx_valid) begin
            case (state_q)
                S_IDLE, S_ERR: begin
                    if (rx_data == SYNC_BYTE) begin
                        csum_d = '0;
                    end
                end
                S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO: csum_d = csum_q ^ rx_data;
                default: csum_d = csum_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end
`endif

    // Frame parser: next state and registered output values.
    always_comb begin
        state_d     = state_q;
        addr_d      = we_q ? addr_q + AW'(1) : addr_q;
        data_d      = data_q;
        we_d        = 1'b0;
        cpu_reset_d = cpu_reset_q;
        done_d      = done_q;
        error_d     = error_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        body_end    = 1'b0;
        finish      = 1'b0;

        if (rx_valid) begin
            case (state_q)
                S_IDLE: begin
                    if (rx_data == SYNC_BYTE) begin
                        state_d = S_LEN_HI;
                        cnt_d   = '0;
                    end
                end
                S_LEN_HI: begin
                    if (rx_data[BW-1]) begin
                        state_d = S_ERR;
                        error_d = 1'b1;
                    end else begin
                        len_d   = {rx_data[BW-2:0], len_q[BW-1:0]};
                        state_d = S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    len_d = {len_q[AW-1:BW], rx_data};
                    if ({len_q[AW-1:BW], rx_data} == AW'(0)) begin
                        body_end = 1'b1;
                    end else begin
                        state_d = S_DATA_HI;
                    end
                end
                S_DATA_HI: begin
                    hi_d    = rx_data;
                    state_d = S_DATA_LO;
                end
                S_DATA_LO: begin
                    data_d = {hi_q, rx_data};
                    we_d   = 1'b1;
                    cnt_d  = cnt_q + AW'(1);
                    if (cnt_q + AW'(1) == len_q) begin
                        body_end = 1'b1;
                    end else begin
                        state_d = S_DATA_HI;
                    end
                end
`ifdef ROM_LOADER_CHECKSUM_EN
                S_CSUM: begin
                    if (rx_data == csum_q) begin
                        finish = 1'b1;
                    end else begin
                        state_d = S_ERR;
                        error_d = 1'b1;
                    end
                end
`endif
                S_DONE: state_d = S_DONE;
                S_ERR: begin
                    // A fresh sync byte restarts the image from address 0.
                    if (rx_data == SYNC_BYTE) begin
                        state_d = S_LEN_HI;
                        error_d = 1'b0;
                        addr_d  = '0;
                        cnt_d   = '0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

`ifdef ROM_LOADER_CHECKSUM_EN
        if (body_end) begin
            state_d = S_CSUM;
        end
`else
        if (body_end) begin
            finish = 1'b1;
        end
`endif

        if (finish) begin
            state_d     = S_DONE;
            done_d      = 1'b1;
            cpu_reset_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            data_q      <= '0;
            we_q        <= 1'b0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            len_q       <= '0;
            cnt_q       <= '0;
            hi_q        <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            we_q        <= we_d;
            cpu_reset_q <= cpu_reset_d;
            done_q      <= done_d;
            error_q     <= error_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
        end
    end

    assign rom_addr  = addr_q;
    assign rom_data  = data_q;
    assign rom_we    = we_q;
    assign cpu_reset = cpu_reset_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule
